gate_sensor_decoder: RTL
========================

# gate_sensor_decoder

Upstream stage of the slot counter: turns two raw infrared beam sensors at the car-park gate into clean single-cycle `car_enter` / `car_leave` pulses and drives the entry barrier. It debounces both beams, tracks crossing direction with a state machine, refuses entry while the car park is full, and flags stuck-sensor faults. Its pulse outputs connect directly to the slot counter's `car_enter` / `car_leave` inputs; its `full` input comes from the counter's `free_slots == 0`.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a beam change is accepted (≥2).
- `TIMEOUT_CYCLES`, default 1024: maximum cycles any crossing state may be held (timeout build only).
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `beam_out`  in  1  outer beam, raw and asynchronous; 1 = blocked.
- `beam_in`  in  1  inner beam, raw and asynchronous; 1 = blocked.
- `full`  in  1  synchronous; 1 = no free slots.
- `car_enter`  out  1  one-cycle pulse per completed entry.
- `car_leave`  out  1  one-cycle pulse per completed exit.
- `gate_open`  out  1  entry barrier command; 1 = raised.
- `fault`  out  1  one-cycle pulse on timeout abort.

## Operation
- Reset (`reset`=0): all outputs 0, FSM in IDLE, synchronisers and debounced beams 0, counters 0.
- Each beam passes through a 2-flop synchroniser, then a debouncer. The debouncer counts cycles in which the synchronised value differs from the debounced value. Any cycle where they match clears the count. The debounced value flips when the count reaches `DEBOUNCE_CYCLES`. Count width is $clog2(DEBOUNCE_CYCLES+1).
- FSM inputs are debounced O (outer) and I (inner). States:
  - IDLE: O only → `full` ? REJECT : EN1. I only → EX1. Both blocked → stay in IDLE.
  - EN1 (O): both → EN2; neither → IDLE, no pulse.
  - EN2 (O,I): I only → EN3; O only → EN1.
  - EN3 (I): neither → IDLE and pulse `car_enter`; both → EN2.
  - EX1 (I): both → EX2; neither → IDLE, no pulse.
  - EX2 (I,O): O only → EX3; I only → EX1.
  - EX3 (O): neither → IDLE and pulse `car_leave`; both → EX2.
  - REJECT: barrier stays down; returns to IDLE only when both beams are clear. Never pulses.
  - WAIT_CLEAR (timeout build only): entered on timeout; returns to IDLE only when both beams are clear.
- All other input combinations hold the current state. No direct diagonal jumps are allowed (for example, EN1 with I only holds).
- `gate_open` = 1 in EN1, EN2, EN3; 0 in every other state. Registered.
- `full` is sampled only at the IDLE→EN1/REJECT decision. A change in `full` mid-crossing does not affect the crossing.
- `car_enter` and `car_leave` are never asserted in the same cycle, and never for two consecutive cycles.

## Timing
- Raw beam edge → debounced edge: `DEBOUNCE_CYCLES`+2 clock edges, provided the input stays stable.
- Debounced change → FSM state / `gate_open` update: 1 edge (registered).
- Final beam clear (raw) → `car_enter`/`car_leave` high: `DEBOUNCE_CYCLES`+3 edges. The pulse lasts exactly 1 cycle.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronised cycles are fully rejected.
- Asynchronous reset mid-crossing: outputs drop immediately, with no pulse for the partial crossing. After release, a vehicle still on the beams only produces a crossing once both beams have been seen clear in IDLE and the full sequence then occurs.

## Configuration
- `GATE_TIMEOUT_EN` defined:
  - A state timer clears on every state change and increments while in any EN*, EX*, or REJECT state.
  - When the timer reaches `TIMEOUT_CYCLES`, the FSM goes to WAIT_CLEAR, pulses `fault` for 1 cycle, drops `gate_open`, and emits no car pulse.
- `GATE_TIMEOUT_EN` undefined: no timer and no WAIT_CLEAR state; `fault` is tied to 0.

## Structure
- Package `gate_pkg`: FSM state encoding (localparams IDLE…WAIT_CLEAR, 4-bit) and the beam-blocked polarity constant.
- Sub-module `sensor_debounce` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `reset`, `raw`, `clean`), instantiated once per beam. The synchroniser lives inside it.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `TIMEOUT_CYCLES`=64.
- Entry O, OI, I, none, each held 10 cycles, with `full`=0 → `gate_open` rises 7 edges after O; one `car_enter` pulse 7 edges after the final clear; `car_leave` stays 0.
- Exit I, IO, O, none → exactly one `car_leave` pulse; `gate_open` stays 0.
- Back-out O, OI, O, none → no pulses; FSM back in IDLE; `gate_open` falls.
- `full`=1 then O, OI, I, none → REJECT; `gate_open` stays 0; no `car_enter`.
- 3-cycle glitch on `beam_out` → no state change. Then `reset` asserted during EN2 → all outputs 0 immediately and no pulse afterwards.
- `GATE_TIMEOUT_EN` build: O held for 100 cycles → `fault` pulses once, 64 cycles after entering EN1; `gate_open` drops; IDLE is reached only after O clears.

Source files
------------

// File: rtl/gate_pkg.sv
// gate_pkg: shared FSM state encoding and beam polarity for the gate sensor decoder.
package gate_pkg;
    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] EN1        = 4'd1;
    localparam logic [3:0] EN2        = 4'd2;
    localparam logic [3:0] EN3        = 4'd3;
    localparam logic [3:0] EX1        = 4'd4;
    localparam logic [3:0] EX2        = 4'd5;
    localparam logic [3:0] EX3        = 4'd6;
    localparam logic [3:0] REJECT     = 4'd7;
    localparam logic [3:0] WAIT_CLEAR = 4'd8;
    localparam logic       BEAM_BLOCKED = 1'b1;
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchroniser followed by a stable-count debouncer for one raw beam.
module sensor_debounce
    import gate_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;
    always_comb begin
        sync_d  = {sync_q[0], raw};
        cnt_d   = (sync_q[1] != clean_q) ? cnt_q + 1'b1 : '0;
        clean_d = clean_q;
        if (cnt_d == CW'(DEBOUNCE_CYCLES)) begin
            clean_d = sync_q[1];
            cnt_d   = '0;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= {2{~BEAM_BLOCKED}};
            cnt_q   <= '0;
            clean_q <= ~BEAM_BLOCKED;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end
    assign clean = clean_q;
endmodule

// File: rtl/gate_sensor_decoder.sv
// gate_sensor_decoder: debounces two gate beams and decodes crossing direction into car pulses and barrier control.
// Define GATE_TIMEOUT_EN to add a crossing timeout with WAIT_CLEAR recovery and a fault pulse.
module gate_sensor_decoder
    import gate_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic beam_out,
    input  logic beam_in,
    input  logic full,
    output logic car_enter,
    output logic car_leave,
    output logic gate_open,
    output logic fault
);
    logic       clean_out, clean_in, o, i;
    logic [3:0] state_q, state_d;
    logic       gate_open_q, gate_open_d, car_enter_q, car_enter_d, car_leave_q, car_leave_d;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_out (
        .clk(clk), .reset(reset), .raw(beam_out), .clean(clean_out)
    );
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_in (
        .clk(clk), .reset(reset), .raw(beam_in), .clean(clean_in)
    );

    assign o = clean_out == BEAM_BLOCKED;
    assign i = clean_in == BEAM_BLOCKED;

`ifdef GATE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          fault_q, fault_d, timed, expired;
    assign timed   = state_q != IDLE && state_q != WAIT_CLEAR;
    assign expired = timed && timer_q == TW'(TIMEOUT_CYCLES - 1);
    always_comb timer_d = (state_d != state_q || !timed) ? '0 : timer_q + 1'b1;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
            fault_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            fault_q <= fault_d;
        end
    end
    assign fault = fault_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            gate_open_q <= 1'b0;
            car_enter_q <= 1'b0;
            car_leave_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gate_open_q <= gate_open_d;
            car_enter_q <= car_enter_d;
            car_leave_q <= car_leave_d;
        end
    end

    // Only adjacent transitions are taken; every other beam combination holds.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (o && !i) state_d = full ? REJECT : EN1; else if (!o && i) state_d = EX1;
            EN1:     if (o && i) state_d = EN2; else if (!o && !i) state_d = IDLE;
            EN2:     if (!o && i) state_d = EN3; else if (o && !i) state_d = EN1;
            EN3:     if (!o && !i) state_d = IDLE; else if (o && i) state_d = EN2;
            EX1:     if (o && i) state_d = EX2; else if (!o && !i) state_d = IDLE;
            EX2:     if (o && !i) state_d = EX3; else if (!o && i) state_d = EX1;
            EX3:     if (!o && !i) state_d = IDLE; else if (o && i) state_d = EX2;
            default: if (!o && !i) state_d = IDLE;
        endcase
`ifdef GATE_TIMEOUT_EN
        if (expired) state_d = WAIT_CLEAR;
`endif
    end

    always_comb begin
        gate_open_d = state_d == EN1 || state_d == EN2 || state_d == EN3;
        car_enter_d = state_q == EN3 && state_d == IDLE;
        car_leave_d = state_q == EX3 && state_d == IDLE;
`ifdef GATE_TIMEOUT_EN
        fault_d = state_d == WAIT_CLEAR && state_q != WAIT_CLEAR;
`endif
    end

    assign gate_open = gate_open_q;
    assign car_enter = car_enter_q;
    assign car_leave = car_leave_q;
endmodule
